// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, with optional even/odd parity bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE = CW'(CLKS_PER_BIT - 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic eob;
  assign eob = cnt == LAST;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt <= (state == IDLE || eob) ? '0 : cnt + CW'(1);
      done <= state == STOP && cnt == PRE;
      case (state)
        IDLE:
          if (tx_start) begin
            state <= START;
            sh <= data_in;
            idx <= '0;
            tx <= 1'b0;
            busy <= 1'b1;
          end
        START:
          if (eob) begin
            state <= DATA;
            tx <= sh[0];
          end
        DATA:
          if (eob) begin
            if (idx == 3'd7) begin
              state <= PARITY != 0 ? PAR : STOP;
              tx <= PARITY != 0 ? (^sh) ^ (PARITY == 2) : 1'b1;
            end else begin
              idx <= idx + 3'd1;
              tx <= sh[idx + 3'd1];
            end
          end
        PAR:
          if (eob) begin
            state <= STOP;
            tx <= 1'b1;
          end
        STOP:
          if (eob) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench driving uart_tx in all three parity modes
module tb_uart_tx;
  localparam int C = 4;
  typedef struct packed {
    logic       abort;
    logic [7:0] data;
    logic       par;
    logic [7:0] gap;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = '0;
  logic [2:0][7:0] data = '0;
  logic [2:0] tx, busy, done;
  int n_cmp = 0;
  int n_err = 0;
  ent_t q0[$], q1[$], q2[$];
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int qsize(input int i);
    return i == 0 ? q0.size() : i == 1 ? q1.size() : q2.size();
  endfunction
  task automatic push(input int i, input ent_t e);
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic pop(input int i, output ent_t e);
    if (i == 0) e = q0.pop_front();
    else if (i == 1) e = q1.pop_front();
    else e = q2.pop_front();
  endtask
  task automatic monitor(input int i);
    int nb, idle_n, done_at;
    ent_t e;
    logic [10:0] fr, ex;
    logic glitch, bsy_bad, aborted, got;
    nb = i == 0 ? 10 : 11;
    idle_n = 0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (tx[i] === 1'b1) begin
        idle_n++;
        chk($sformatf("idle_busy%0d", i), busy[i], 0);
        chk($sformatf("idle_done%0d", i), done[i], 0);
      end else begin
        got = qsize(i) != 0;
        chk($sformatf("unexpected_frame%0d", i), got, 1);
        e = '0;
        if (got) pop(i, e);
        if (e.gap != 0) chk($sformatf("gap%0d", i), idle_n, e.gap);
        fr = '0;
        glitch = 0;
        bsy_bad = 0;
        aborted = 0;
        done_at = -1;
        for (int n = 0; n < nb * C && !aborted; n++) begin
          if (n != 0) @(negedge clk);
          if (n % C == 0) fr[n / C] = tx[i];
          else if (tx[i] !== fr[n / C]) glitch = 1;
          if (busy[i] !== 1'b1) bsy_bad = 1;
          if (done[i] === 1'b1 && done_at < 0) done_at = n + 1;
          if (!rst_n) aborted = 1;
        end
        chk($sformatf("abort%0d", i), aborted, e.abort);
        if (aborted) begin
          @(negedge clk);
          chk($sformatf("rst_tx%0d", i), tx[i], 1);
          chk($sformatf("rst_busy%0d", i), busy[i], 0);
          chk($sformatf("rst_done%0d", i), done[i], 0);
          chk($sformatf("rst_no_done%0d", i), done_at, -1);
        end else begin
          ex = i == 0 ? {1'b0, 1'b1, e.data, 1'b0} : {1'b1, e.par, e.data, 1'b0};
          chk($sformatf("frame%0d", i), fr, ex);
          chk($sformatf("bit_stable%0d", i), glitch, 0);
          chk($sformatf("frame_busy%0d", i), bsy_bad, 0);
          chk($sformatf("done_cycle%0d", i), done_at, nb * C);
        end
        idle_n = 0;
      end
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_u
    uart_tx #(.CLKS_PER_BIT(C), .PARITY(g)) u (
      .clk(clk),
      .rst_n(rst_n),
      .tx_start(start[g]),
      .data_in(data[g]),
      .tx(tx[g]),
      .busy(busy[g]),
      .done(done[g])
    );
    initial monitor(g);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int i, input logic [7:0] d, input logic p, input logic ab, input logic [7:0] gp);
    push(i, '{abort: ab, data: d, par: p, gap: gp});
    start[i] = 1'b1;
    data[i] = d;
    tick();
    start[i] = 1'b0;
  endtask
  task automatic wait_done(input int i);
    int n;
    n = 0;
    while (done[i] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("done_timeout%0d", i), n < 200, 1);
    tick();
  endtask
  initial begin
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_tx%0d", i), tx[i], 1);
      chk($sformatf("reset_busy%0d", i), busy[i], 0);
      chk($sformatf("reset_done%0d", i), done[i], 0);
    end
    rst_n = 1'b1;
    send(0, 8'hA5, 1'b0, 1'b0, 8'd0);
    wait_done(0);
    push(1, '{abort: 1'b0, data: 8'h07, par: 1'b1, gap: 8'd0});
    push(2, '{abort: 1'b0, data: 8'h07, par: 1'b0, gap: 8'd0});
    start[1] = 1'b1;
    start[2] = 1'b1;
    data[1] = 8'h07;
    data[2] = 8'h07;
    tick();
    start[1] = 1'b0;
    start[2] = 1'b0;
    data[1] = 8'hF8;
    data[2] = 8'hF8;
    wait_done(1);
    send(0, 8'h11, 1'b0, 1'b0, 8'd0);
    repeat (9) tick();
    start[0] = 1'b1;
    data[0] = 8'hFF;
    tick();
    start[0] = 1'b0;
    wait_done(0);
    repeat (60) tick();
    send(0, 8'h81, 1'b0, 1'b0, 8'd0);
    wait_done(0);
    send(0, 8'h42, 1'b0, 1'b0, 8'd1);
    wait_done(0);
    repeat (5) tick();
    send(0, 8'hC3, 1'b0, 1'b1, 8'd0);
    repeat (17) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy_now", busy[0], 0);
    send(0, 8'h3C, 1'b0, 1'b0, 8'd0);
    wait_done(0);
    tick();
    rst_n = 1'b0;
    start[0] = 1'b1;
    data[0] = 8'h99;
    tick();
    rst_n = 1'b1;
    start[0] = 1'b0;
    repeat (3) tick();
    chk("rst_start_tx", tx[0], 1);
    chk("rst_start_busy", busy[0], 0);
    repeat (60) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("queue_empty%0d", i), qsize(i), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
